// File: rtl/fas_checker.sv
// Self-checking monitor for a 1-bit full adder/subtractor: compares observed
// s/cout against a reference, tracks input coverage and records the first failure.
module fas_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             valid,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    input  logic             a_ns,
    input  logic             s,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [15:0]      coverage,
    output logic [5:0]       first_fail,
    output logic             first_fail_vld,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [15:0]      coverage_q, coverage_d;
    logic [5:0]       first_fail_q, first_fail_d;
    logic             first_fail_vld_q, first_fail_vld_d;

    logic        s_exp;
    logic        cout_exp;
    logic        mismatch;
    logic        accept;
    logic [3:0]  combo_idx;
    logic [15:0] combo_bit;

    // Handshake: valid has no back-pressure; an observation is consumed on any
    // rising edge where the checker is ARMED, valid=1 and start=0, otherwise dropped.
    always_comb begin
        s_exp     = a ^ b ^ cin;
        cout_exp  = a_ns ? ((a & b) | (a & cin) | (b & cin))
                         : ((~a & b) | (~a & cin) | (b & cin));
        mismatch  = ({s, cout} != {s_exp, cout_exp});
        accept    = (state_q == ST_ARMED) && valid && !start;
        combo_idx = {a_ns, a, b, cin};
        combo_bit = 16'd1 << combo_idx;
    end

    always_comb begin
        state_d          = state_q;
        vec_cnt_d        = vec_cnt_q;
        err_cnt_d        = err_cnt_q;
        coverage_d       = coverage_q;
        first_fail_d     = first_fail_q;
        first_fail_vld_d = first_fail_vld_q;
        if (start) begin
            state_d          = ST_ARMED;
            vec_cnt_d        = '0;
            err_cnt_d        = '0;
            coverage_d       = '0;
            first_fail_d     = '0;
            first_fail_vld_d = 1'b0;
        end else if (accept) begin
            if (vec_cnt_q != CNT_MAX) begin
                vec_cnt_d = vec_cnt_q + CNT_ONE;
            end
            if (mismatch) begin
                if (err_cnt_q != CNT_MAX) begin
                    err_cnt_d = err_cnt_q + CNT_ONE;
                end
                if (!first_fail_vld_q) begin
                    first_fail_d     = {a_ns, a, b, cin, s, cout};
                    first_fail_vld_d = 1'b1;
                end
            end
            coverage_d = coverage_q | combo_bit;
            // The accepting edge that completes coverage also moves us to DONE.
            if (coverage_d == 16'hFFFF) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            vec_cnt_q        <= '0;
            err_cnt_q        <= '0;
            coverage_q       <= '0;
            first_fail_q     <= '0;
            first_fail_vld_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            vec_cnt_q        <= vec_cnt_d;
            err_cnt_q        <= err_cnt_d;
            coverage_q       <= coverage_d;
            first_fail_q     <= first_fail_d;
            first_fail_vld_q <= first_fail_vld_d;
        end
    end

    always_comb begin
        busy           = (state_q == ST_ARMED);
        done           = (state_q == ST_DONE);
        pass           = done && (err_cnt_q == '0);
        vec_cnt        = vec_cnt_q;
        err_cnt        = err_cnt_q;
        coverage       = coverage_q;
        first_fail     = first_fail_q;
        first_fail_vld = first_fail_vld_q;
        state_dbg      = state_q;
    end

endmodule

// File: tb/tb_fas_checker.sv
// Directed bench for fas_checker: table-driven exhaustive pass plus hand-written
// first-fail, collision, reset, DONE-hold and saturation sequences.
module tb_fas_checker;

    logic clk;
    logic rst_n;
    logic start, valid, a, b, cin, a_ns, s, cout;

    logic       busy, done, pass, ffv;
    logic [7:0] vec_cnt, err_cnt;
    logic [15:0] coverage;
    logic [5:0] first_fail;
    logic [1:0] state_dbg;

    logic       busy4, done4, pass4, ffv4;
    logic [3:0] vec_cnt4, err_cnt4;
    logic [15:0] coverage4;
    logic [5:0] first_fail4;
    logic [1:0] state_dbg4;

    int n_checks;
    int n_fail;

    fas_checker #(.CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .valid(valid),
        .a(a), .b(b), .cin(cin), .a_ns(a_ns), .s(s), .cout(cout),
        .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt),
        .err_cnt(err_cnt), .coverage(coverage), .first_fail(first_fail),
        .first_fail_vld(ffv), .state_dbg(state_dbg)
    );

    fas_checker #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .valid(valid),
        .a(a), .b(b), .cin(cin), .a_ns(a_ns), .s(s), .cout(cout),
        .busy(busy4), .done(done4), .pass(pass4), .vec_cnt(vec_cnt4),
        .err_cnt(err_cnt4), .coverage(coverage4), .first_fail(first_fail4),
        .first_fail_vld(ffv4), .state_dbg(state_dbg4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] combo;
        logic [1:0] sc;
        logic [7:0] exp_vec;
        logic       exp_done;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic formulation of the adder/subtractor, used for bulk good vectors.
    function automatic logic [1:0] ref_sc(input logic [3:0] c);
        int av, bv, cv, r;
        logic [1:0] res;
        av = int'(c[2]);
        bv = int'(c[1]);
        cv = int'(c[0]);
        if (c[3]) begin
            r = av + bv + cv;
            res = {(r % 2) == 1, r >= 2};
        end else begin
            r = av - bv - cv;
            res = {(r % 2) != 0, r < 0};
        end
        return res;
    endfunction

    // driver: apply one cycle of inputs, return #1 after the edge
    task automatic drive(input logic st, input logic vl, input logic [3:0] combo, input logic [1:0] sc);
        start = st;
        valid = vl;
        {a_ns, a, b, cin} = combo;
        {s, cout} = sc;
        @(posedge clk);
        #1;
        start = 1'b0;
        valid = 1'b0;
    endtask

    task automatic pulse_start();
        drive(1'b1, 1'b0, 4'd0, 2'b00);
    endtask

    initial begin
        logic [15:0] exp_cov;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        start = 1'b0; valid = 1'b0;
        a = 1'b0; b = 1'b0; cin = 1'b0; a_ns = 1'b0; s = 1'b0; cout = 1'b0;

        tbl[0]  = '{4'b1000, 2'b00, 8'd1,  1'b0};
        tbl[1]  = '{4'b1001, 2'b10, 8'd2,  1'b0};
        tbl[2]  = '{4'b1010, 2'b10, 8'd3,  1'b0};
        tbl[3]  = '{4'b1011, 2'b01, 8'd4,  1'b0};
        tbl[4]  = '{4'b1100, 2'b10, 8'd5,  1'b0};
        tbl[5]  = '{4'b1101, 2'b01, 8'd6,  1'b0};
        tbl[6]  = '{4'b1110, 2'b01, 8'd7,  1'b0};
        tbl[7]  = '{4'b1111, 2'b11, 8'd8,  1'b0};
        tbl[8]  = '{4'b0000, 2'b00, 8'd9,  1'b0};
        tbl[9]  = '{4'b0001, 2'b11, 8'd10, 1'b0};
        tbl[10] = '{4'b0010, 2'b11, 8'd11, 1'b0};
        tbl[11] = '{4'b0011, 2'b01, 8'd12, 1'b0};
        tbl[12] = '{4'b0100, 2'b10, 8'd13, 1'b0};
        tbl[13] = '{4'b0101, 2'b00, 8'd14, 1'b0};
        tbl[14] = '{4'b0110, 2'b00, 8'd15, 1'b0};
        tbl[15] = '{4'b0111, 2'b11, 8'd16, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // reset state, and valid without start is ignored in IDLE
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        drive(1'b0, 1'b1, 4'b1000, 2'b00);
        check("idle_vec", 32'(vec_cnt), 32'd0);
        check("idle_cov", 32'(coverage), 32'd0);

        // exhaustive correct pass
        pulse_start();
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_state", 32'(state_dbg), 32'd1);
        exp_cov = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, tbl[i].combo, tbl[i].sc);
            exp_cov = exp_cov | (16'd1 << tbl[i].combo);
            check($sformatf("t1_vec[%0d]", i), 32'(vec_cnt), 32'(tbl[i].exp_vec));
            check($sformatf("t1_err[%0d]", i), 32'(err_cnt), 32'd0);
            check($sformatf("t1_cov[%0d]", i), 32'(coverage), 32'(exp_cov));
            check($sformatf("t1_done[%0d]", i), 32'(done), 32'(tbl[i].exp_done));
            check($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(!tbl[i].exp_done));
        end
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_cov_full", 32'(coverage), 32'hFFFF);
        check("t1_ffv", 32'(ffv), 32'd0);

        // first-fail capture
        pulse_start();
        check("t2_clr_vec", 32'(vec_cnt), 32'd0);
        check("t2_clr_cov", 32'(coverage), 32'd0);
        drive(1'b0, 1'b1, 4'b0010, 2'b10);
        check("t2_err1", 32'(err_cnt), 32'd1);
        check("t2_ffv1", 32'(ffv), 32'd1);
        check("t2_ff1", 32'(first_fail), 32'b001010);
        drive(1'b0, 1'b1, 4'b1111, 2'b01);
        check("t2_err2", 32'(err_cnt), 32'd2);
        check("t2_ff2", 32'(first_fail), 32'b001010);
        for (int c = 0; c < 16; c++) begin
            if (c != 2 && c != 15) drive(1'b0, 1'b1, 4'(c), ref_sc(4'(c)));
        end
        check("t2_done", 32'(done), 32'd1);
        check("t2_pass", 32'(pass), 32'd0);
        check("t2_vec", 32'(vec_cnt), 32'd16);
        check("t2_err", 32'(err_cnt), 32'd2);
        check("t2_ff_final", 32'(first_fail), 32'b001010);

        // DONE hold, then restart
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 4'(i), 2'b11);
        check("t5_vec", 32'(vec_cnt), 32'd16);
        check("t5_err", 32'(err_cnt), 32'd2);
        check("t5_done", 32'(done), 32'd1);
        check("t5_state", 32'(state_dbg), 32'd2);
        pulse_start();
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_done0", 32'(done), 32'd0);
        check("t5_vec0", 32'(vec_cnt), 32'd0);
        check("t5_err0", 32'(err_cnt), 32'd0);
        check("t5_cov0", 32'(coverage), 32'd0);
        check("t5_ffv0", 32'(ffv), 32'd0);
        check("t5_ff0", 32'(first_fail), 32'd0);

        // start/valid collision: start wins, observation dropped
        drive(1'b0, 1'b1, 4'b1000, 2'b00);
        check("t3_pre_vec", 32'(vec_cnt), 32'd1);
        drive(1'b1, 1'b1, 4'b1001, 2'b00);
        check("t3_vec", 32'(vec_cnt), 32'd0);
        check("t3_cov", 32'(coverage), 32'd0);
        check("t3_err", 32'(err_cnt), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);

        // asynchronous reset mid-collection
        for (int c = 0; c < 5; c++) drive(1'b0, 1'b1, 4'(c), ref_sc(4'(c)));
        check("t4_vec5", 32'(vec_cnt), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_vec", 32'(vec_cnt), 32'd0);
        check("t4_cov", 32'(coverage), 32'd0);
        check("t4_misc", 32'({done, pass, ffv, err_cnt, first_fail}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 4'(i), 2'b11);
        check("t4_idle_vec", 32'(vec_cnt), 32'd0);
        check("t4_idle_busy", 32'(busy), 32'd0);

        // saturation at CNT_W=4, repeated combo never completes coverage
        pulse_start();
        for (int i = 1; i <= 20; i++) begin
            drive(1'b0, 1'b1, 4'b1000, 2'b10);
            if (i == 14 || i == 15) begin
                check($sformatf("t6_vec4_at%0d", i), 32'(vec_cnt4), 32'(i));
            end
        end
        check("t6_vec4", 32'(vec_cnt4), 32'd15);
        check("t6_err4", 32'(err_cnt4), 32'd15);
        check("t6_busy4", 32'(busy4), 32'd1);
        check("t6_vec8", 32'(vec_cnt), 32'd20);
        check("t6_err8", 32'(err_cnt), 32'd20);
        check("t6_ff4", 32'(first_fail4), 32'b100010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fas_checker.md
FAS_CHECKER -- requirements
Module: fas_checker

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the vector and error counters.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle pulse; clears all results and arms the checker.
REQ-005 SHALL have port valid  input  1  current a/b/cin/a_ns/s/cout form one observation.
REQ-006 SHALL have ports a, b, cin, a_ns  input  1 each  stimulus applied to the full adder/subtractor; a_ns=1 add, a_ns=0 subtract.
REQ-007 SHALL have ports s, cout  input  1 each  outputs observed from the full adder/subtractor.
REQ-008 SHALL have port busy  output  1  checker armed and collecting.
REQ-009 SHALL have port done  output  1  all 16 input combinations covered.
REQ-010 SHALL have port pass  output  1  done and zero mismatches.
REQ-011 SHALL have port vec_cnt  output  CNT_W  accepted observations, saturating.
REQ-012 SHALL have port err_cnt  output  CNT_W  mismatching observations, saturating.
REQ-013 SHALL have port coverage  output  16  bit {a_ns,a,b,cin} set once that combination is observed.
REQ-014 SHALL have port first_fail  output  6  {a_ns,a,b,cin,s,cout} of the first mismatch.
REQ-015 SHALL have port first_fail_vld  output  1  first_fail holds a captured mismatch.

Function
REQ-016 SHALL compute add reference (a_ns=1): s_exp=a^b^cin, cout_exp=(a&b)|(a&cin)|(b&cin).
REQ-017 SHALL compute subtract reference (a_ns=0), a-b-cin: s_exp=a^b^cin, cout_exp=borrow=(~a&b)|(~a&cin)|(b&cin).
REQ-018 SHALL implement FSM IDLE, ARMED, DONE; reset state IDLE.
REQ-019 SHALL transition any state -> ARMED on start, clearing vec_cnt, err_cnt, coverage, first_fail, first_fail_vld.
REQ-020 SHALL accept an observation only when state==ARMED, valid=1, start=0; valid ignored in IDLE and DONE.
REQ-021 SHALL, on an accepted observation at edge N, present updated vec_cnt, err_cnt, coverage, first_fail* after edge N (1-cycle latency).
REQ-022 SHALL count a mismatch when {s,cout} != {s_exp,cout_exp}.
REQ-023 SHALL capture first_fail only on the first mismatch after start; later mismatches do not overwrite it.
REQ-024 SHALL saturate vec_cnt and err_cnt at 2^CNT_W-1, with no wrap.
REQ-025 SHALL transition ARMED -> DONE on the edge where coverage becomes 16'hFFFF, including the accepting edge itself.
REQ-026 SHALL drive busy=(state==ARMED) and done=(state==DONE), both registered-state decodes.
REQ-027 SHALL drive pass=done&(err_cnt==0).
REQ-028 SHALL, when start and valid coincide, let start win; that observation is dropped and not counted.
REQ-029 SHALL retain all results in DONE until the next start or reset.
REQ-030 SHALL count repeated observations of an already-covered combination in vec_cnt and check them normally.

Reset
REQ-031 SHALL, on rst_n low at any time including mid-collection, force state IDLE: busy=0, done=0, pass=0, vec_cnt=0, err_cnt=0, coverage=0, first_fail=0, first_fail_vld=0.
REQ-032 SHALL stay in IDLE after rst_n deasserts until start.

Verification
REQ-033 SHALL cover exhaustive add pass: start, then 8 correct vectors with a_ns=1 and 8 with a_ns=0 -> done=1, pass=1, vec_cnt=16, err_cnt=0, coverage=16'hFFFF.
REQ-034 SHALL cover first-fail capture: a_ns=0,a=0,b=1,cin=0 observed s=1,cout=0 (expected s=1,cout=1), then a second bad vector -> err_cnt=2, first_fail=6'b001010, first_fail_vld=1, pass=0 at done.
REQ-035 SHALL cover start/valid collision: start and valid in the same cycle -> vec_cnt=0 and coverage=0 in the next cycle.
REQ-036 SHALL cover reset mid-operation: rst_n low after 5 accepted vectors -> all outputs 0 asynchronously; valid without start afterwards -> vec_cnt stays 0.
REQ-037 SHALL cover saturation with CNT_W=4: 20 accepted vectors, every one mismatching -> vec_cnt=15, err_cnt=15.
REQ-038 SHALL cover DONE hold: valid pulses after done -> counters unchanged; a new start -> busy=1 and all results cleared.
